// File: rtl/switch_egress_pkg.sv
// Shared types and constants for the per-port egress transmitter.
// The FSM state encoding, descriptor field layout and statistics counter widths live here.
package switch_egress_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    IFG  = 2'd3
  } state_t;

  localparam int PTR_W     = 16;
  localparam int LEN_LSB   = 0;
  localparam int LEN_W_DEF = 11;
  localparam int IFG_CNT_W = 8;

  localparam int STAT_FRAMES_W  = 32;
  localparam int STAT_BYTES_W   = 32;
  localparam int STAT_LEN_ERR_W = 16;

endpackage

// File: rtl/switch_egress_stats.sv
// Free-running frame, byte and length-error counters for one egress port.
// All counters wrap naturally; they only exist in builds with SWITCH_EGRESS_STATS_EN.
module switch_egress_stats
  import switch_egress_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_inc,
  input  logic        byte_inc,
  input  logic        err_inc,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_bytes,
  output logic [15:0] stat_len_err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames  <= '0;
      stat_bytes   <= '0;
      stat_len_err <= '0;
    end else begin
      if (frame_inc) stat_frames  <= stat_frames + STAT_FRAMES_W'(1);
      if (byte_inc)  stat_bytes   <= stat_bytes + STAT_BYTES_W'(1);
      if (err_inc)   stat_len_err <= stat_len_err + STAT_LEN_ERR_W'(1);
    end
  end

endmodule

// File: rtl/switch_egress_tx.sv
// Per-port egress transmitter: pops a length descriptor, streams that many bytes with sof/dv/eof
// framing and a fixed inter-frame gap. Optional statistics under macro SWITCH_EGRESS_STATS_EN.
module switch_egress_tx
  import switch_egress_pkg::*;
#(
  parameter int IFG_CYCLES = 10,
  parameter int MAX_LEN    = 1518,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ptr_fifo_empty,
  input  logic [15:0] ptr_fifo_dout,
  output logic        ptr_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic        data_fifo_rd,
  input  logic        tx_pause,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        tx_dv,
  output logic [7:0]  tx_dout,
  output logic        busy,
  output logic        len_err
`ifdef SWITCH_EGRESS_STATS_EN
  ,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_bytes,
  output logic [15:0] stat_len_err
`endif
);

  localparam logic [IFG_CNT_W-1:0] IFG_LOAD  = IFG_CNT_W'(IFG_CYCLES - 1);
  localparam logic [31:0]          MAX_LEN_U = 32'(MAX_LEN);

  state_t               state, state_nx;
  logic [LEN_W-1:0]     cnt, cnt_nx;
  logic [LEN_W-1:0]     len_in;
  logic [IFG_CNT_W-1:0] ifg_cnt, ifg_cnt_nx;
  logic                 first_rd, first_rd_nx;
  logic                 ptr_rd_nx, data_rd_nx, len_err_nx, busy_nx;
  logic                 start;
  logic                 vld_p0, sof_p0, eof_p0;
  logic                 unused_resv;

  assign len_in      = ptr_fifo_dout[LEN_LSB +: LEN_W];
  assign unused_resv = ^ptr_fifo_dout[PTR_W-1:LEN_LSB+LEN_W];
  assign start       = !ptr_fifo_empty && !tx_pause;

  // Outputs are registered, so every decision is made one cycle ahead of the strobe it drives.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ifg_cnt_nx  = ifg_cnt;
    first_rd_nx = 1'b0;
    ptr_rd_nx   = 1'b0;
    data_rd_nx  = 1'b0;
    len_err_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = LOAD;
          ptr_rd_nx = 1'b1;
        end
      end
      LOAD: begin
        // First LOAD cycle is the pop itself; the descriptor is valid on the second.
        if (!ptr_fifo_rd) begin
          if (len_in == '0) begin
            len_err_nx = 1'b1;
            if (start) begin
              state_nx  = LOAD;
              ptr_rd_nx = 1'b1;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            len_err_nx  = (32'(len_in) > MAX_LEN_U);
            cnt_nx      = len_in - LEN_W'(1);
            data_rd_nx  = 1'b1;
            first_rd_nx = 1'b1;
            state_nx    = SEND;
          end
        end
      end
      SEND: begin
        if (cnt == '0) begin
          state_nx   = IFG;
          ifg_cnt_nx = IFG_LOAD;
        end else begin
          cnt_nx     = cnt - LEN_W'(1);
          data_rd_nx = 1'b1;
        end
      end
      IFG: begin
        if (ifg_cnt == '0) begin
          if (start) begin
            state_nx  = LOAD;
            ptr_rd_nx = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          ifg_cnt_nx = ifg_cnt - IFG_CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ifg_cnt      <= '0;
      first_rd     <= 1'b0;
      ptr_fifo_rd  <= 1'b0;
      data_fifo_rd <= 1'b0;
      len_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      ifg_cnt      <= ifg_cnt_nx;
      first_rd     <= first_rd_nx;
      ptr_fifo_rd  <= ptr_rd_nx;
      data_fifo_rd <= data_rd_nx;
      len_err      <= len_err_nx;
      busy         <= busy_nx;
    end
  end

  // Stage p0: read strobe in flight, FIFO byte arrives on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      sof_p0 <= 1'b0;
      eof_p0 <= 1'b0;
    end else begin
      vld_p0 <= data_fifo_rd;
      sof_p0 <= first_rd;
      eof_p0 <= (state == SEND) && (cnt == '0);
    end
  end

  // Output stage: capture the byte; tx_dout holds between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_dv   <= 1'b0;
      tx_sof  <= 1'b0;
      tx_eof  <= 1'b0;
      tx_dout <= '0;
    end else begin
      tx_dv  <= vld_p0;
      tx_sof <= vld_p0 && sof_p0;
      tx_eof <= vld_p0 && eof_p0;
      if (vld_p0) tx_dout <= data_fifo_dout;
    end
  end

`ifdef SWITCH_EGRESS_STATS_EN
  switch_egress_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .frame_inc    (tx_eof),
    .byte_inc     (tx_dv),
    .err_inc      (len_err),
    .stat_frames  (stat_frames),
    .stat_bytes   (stat_bytes),
    .stat_len_err (stat_len_err)
  );
`endif

endmodule

// File: tb/tb_switch_egress_tx.sv
// Self-checking bench for switch_egress_tx: descriptor table, timing corner sequences and a
// randomized descriptor stream checked against a frame-level reference model.
module tb_switch_egress_tx;

  localparam int IFG_CYCLES = 10;
  localparam int MAX_LEN    = 1518;
  localparam int LEN_W      = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ptr_fifo_empty = 1'b1;
  logic [15:0] ptr_fifo_dout = '0;
  logic        ptr_fifo_rd;
  logic [7:0]  data_fifo_dout = '0;
  logic        data_fifo_rd;
  logic        tx_pause = 1'b0;
  logic        tx_sof, tx_eof, tx_dv;
  logic [7:0]  tx_dout;
  logic        busy, len_err;
`ifdef SWITCH_EGRESS_STATS_EN
  logic [31:0] stat_frames, stat_bytes;
  logic [15:0] stat_len_err;
`endif

  switch_egress_tx #(
    .IFG_CYCLES (IFG_CYCLES),
    .MAX_LEN    (MAX_LEN),
    .LEN_W      (LEN_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ptr_fifo_empty (ptr_fifo_empty),
    .ptr_fifo_dout  (ptr_fifo_dout),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .data_fifo_dout (data_fifo_dout),
    .data_fifo_rd   (data_fifo_rd),
    .tx_pause       (tx_pause),
    .tx_sof         (tx_sof),
    .tx_eof         (tx_eof),
    .tx_dv          (tx_dv),
    .tx_dout        (tx_dout),
    .busy           (busy),
    .len_err        (len_err)
`ifdef SWITCH_EGRESS_STATS_EN
    ,
    .stat_frames    (stat_frames),
    .stat_bytes     (stat_bytes),
    .stat_len_err   (stat_len_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       sof;
    logic       eof;
  } tx_rec_t;

  typedef struct {
    logic [15:0] word;
    logic [7:0]  seed;
    int          exp_len;
    int          exp_err;
  } vec_t;

  logic [15:0] ptr_q[$];
  logic [7:0]  data_q[$];
  int          ptr_rd_cyc[$];
  int          rd_cyc[$];
  int          err_cyc[$];
  tx_rec_t     tx_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          stray = 0;
  logic        prev_ptr_rd = 1'b0;
  logic        prev_data_rd = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: FIFO models respond to last cycle's pops, then the new cycle's outputs are logged.
  task automatic tick();
    tx_rec_t r;
    @(posedge clk);
    #1;
    cyc++;
    if (prev_ptr_rd && ptr_q.size() > 0) ptr_fifo_dout = ptr_q.pop_front();
    if (prev_data_rd) data_fifo_dout = (data_q.size() > 0) ? data_q.pop_front() : 8'h00;
    ptr_fifo_empty = (ptr_q.size() == 0);
    prev_ptr_rd  = ptr_fifo_rd;
    prev_data_rd = data_fifo_rd;
    if (ptr_fifo_rd)  ptr_rd_cyc.push_back(cyc);
    if (data_fifo_rd) rd_cyc.push_back(cyc);
    if (len_err)      err_cyc.push_back(cyc);
    if (tx_dv) begin
      r.cyc = cyc; r.d = tx_dout; r.sof = tx_sof; r.eof = tx_eof;
      tx_q.push_back(r);
    end
    if ((tx_sof || tx_eof) && !tx_dv) stray++;
  endtask

  task automatic clear_mon();
    ptr_rd_cyc.delete(); rd_cyc.delete(); err_cyc.delete(); tx_q.delete();
  endtask

  task automatic push_frame(input logic [15:0] word, input int len, input logic [7:0] seed);
    ptr_q.push_back(word);
    for (int i = 0; i < len; i++) data_q.push_back(8'(seed + 8'(i)));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int run = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && ptr_fifo_empty && !tx_dv) run++;
      else run = 0;
      if (run >= 4) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles, busy=%0d", name, budget, busy);
  endtask

  function automatic int outputs_word();
    return int'({ptr_fifo_rd, data_fifo_rd, tx_sof, tx_eof, tx_dv, tx_dout, busy, len_err});
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int t = 0, bad = 0, nsof = 0, neof = 0, n;
    string tag;
    tag = $sformatf("vec%0d", idx);
    clear_mon();
    push_frame(v.word, v.exp_len, v.seed);
    wait_idle({tag, "_idle"}, v.exp_len + IFG_CYCLES + 60);
    chk({tag, "_pops"}, ptr_rd_cyc.size(), 1);
    if (ptr_rd_cyc.size() > 0) t = ptr_rd_cyc[0];
    chk({tag, "_len_err_cnt"}, err_cyc.size(), v.exp_err);
    if (v.exp_err != 0 && err_cyc.size() > 0) chk({tag, "_len_err_cyc"}, err_cyc[0], t + 2);
    chk({tag, "_rd_cnt"}, rd_cyc.size(), v.exp_len);
    n = tx_q.size();
    chk({tag, "_tx_cnt"}, n, v.exp_len);
    if (v.exp_len > 0 && rd_cyc.size() > 0 && n > 0) begin
      chk({tag, "_rd_first"}, rd_cyc[0], t + 2);
      chk({tag, "_rd_last"}, rd_cyc[rd_cyc.size()-1], t + 1 + v.exp_len);
      chk({tag, "_tx_first"}, tx_q[0].cyc, t + 4);
      chk({tag, "_tx_last"}, tx_q[n-1].cyc, t + 3 + v.exp_len);
      for (int i = 0; i < n; i++) begin
        if (tx_q[i].d != 8'(v.seed + 8'(i))) bad++;
        if (tx_q[i].sof) nsof++;
        if (tx_q[i].eof) neof++;
      end
      chk({tag, "_bytes_bad"}, bad, 0);
      chk({tag, "_sof_cnt"}, nsof, 1);
      chk({tag, "_eof_cnt"}, neof, 1);
      chk({tag, "_sof_pos"}, int'(tx_q[0].sof), 1);
      chk({tag, "_eof_pos"}, int'(tx_q[n-1].eof), 1);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int t, bad, n, guard;
    int exp_lens[$];
    int exp_gaps[$];
    logic [7:0] exp_bytes[$];
    int sof_cycs[$];
    int eof_cycs[$];
    int exp_errs, zeros, len, r, nfr;
    logic [7:0] b;

    vecs[0] = '{16'h0040, 8'h00, 64,   0};
    vecs[1] = '{16'h0001, 8'hA5, 1,    0};
    vecs[2] = '{16'h0000, 8'h00, 0,    1};
    vecs[3] = '{16'hF800, 8'h00, 0,    1};
    vecs[4] = '{16'h0802, 8'h3C, 2,    0};
    vecs[5] = '{16'h05EE, 8'h11, 1518, 0};
    vecs[6] = '{16'h05EF, 8'h22, 1519, 1};
    vecs[7] = '{16'hFFFF, 8'hF0, 2047, 1};

    // Reset state
    repeat (3) tick();
    chk("reset_outputs", outputs_word(), 0);
    rst = 1'b0;
`ifdef SWITCH_EGRESS_STATS_EN
    chk("reset_stat_frames", int'(stat_frames), 0);
    chk("reset_stat_bytes", int'(stat_bytes), 0);
    chk("reset_stat_len_err", int'(stat_len_err), 0);
`endif
    repeat (2) tick();
    chk("idle_busy", int'(busy), 0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back len=60 frames: gap and order
    clear_mon();
    push_frame(16'h003C, 60, 8'h10);
    push_frame(16'h003C, 60, 8'h80);
    wait_idle("b2b_idle", 400);
    chk("b2b_tx_cnt", tx_q.size(), 120);
    if (tx_q.size() == 120) begin
      chk("b2b_gap", tx_q[60].cyc - tx_q[59].cyc - 1, IFG_CYCLES + 2);
      chk("b2b_eof1", int'(tx_q[59].eof), 1);
      chk("b2b_sof2", int'(tx_q[60].sof), 1);
      bad = 0;
      for (int i = 0; i < 120; i++)
        if (tx_q[i].d != ((i < 60) ? 8'(8'h10 + 8'(i)) : 8'(8'h80 + 8'(i - 60)))) bad++;
      chk("b2b_bytes_bad", bad, 0);
    end

    // len=0 immediately followed by len=1
    clear_mon();
    push_frame(16'h0000, 0, 8'h00);
    push_frame(16'h0001, 1, 8'hA5);
    wait_idle("zero_one_idle", 200);
    chk("zero_one_len_err", err_cyc.size(), 1);
    chk("zero_one_rd_cnt", rd_cyc.size(), 1);
    chk("zero_one_tx_cnt", tx_q.size(), 1);
    if (tx_q.size() == 1) begin
      chk("zero_one_sof_eof", int'({tx_q[0].sof, tx_q[0].eof}), 3);
      chk("zero_one_dout", int'(tx_q[0].d), 8'hA5);
    end

    // Pause in IDLE blocks the pop; pause during SEND has no effect
    clear_mon();
    tx_pause = 1'b1;
    push_frame(16'h001E, 30, 8'h40);
    repeat (20) tick();
    chk("pause_no_pop", ptr_rd_cyc.size(), 0);
    tx_pause = 1'b0;
    guard = 0;
    while (rd_cyc.size() < 5 && guard < 60) begin tick(); guard++; end
    chk("pause_send_started", int'(rd_cyc.size() >= 5), 1);
    tx_pause = 1'b1;
    wait_idle("pause_idle", 200);
    tx_pause = 1'b0;
    chk("pause_tx_cnt", tx_q.size(), 30);
    if (tx_q.size() == 30) begin
      bad = 0;
      for (int i = 0; i < 30; i++) if (tx_q[i].d != 8'(8'h40 + 8'(i))) bad++;
      chk("pause_bytes_bad", bad, 0);
      chk("pause_contig", tx_q[29].cyc - tx_q[0].cyc + 1, 30);
    end

    // Reset mid-SEND
    clear_mon();
    push_frame(16'h0064, 100, 8'h00);
    guard = 0;
    while (tx_q.size() < 10 && guard < 100) begin tick(); guard++; end
    chk("midrst_in_frame", int'(busy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", outputs_word(), 0);
    ptr_q.delete();
    data_q.delete();
    prev_ptr_rd = 1'b0;
    prev_data_rd = 1'b0;
    ptr_fifo_empty = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    clear_mon();
    repeat (10) tick();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_no_pop", ptr_rd_cyc.size(), 0);

`ifdef SWITCH_EGRESS_STATS_EN
    clear_mon();
    push_frame(16'h0040, 64, 8'h00);
    push_frame(16'h0000, 0, 8'h00);
    push_frame(16'h0080, 128, 8'h55);
    wait_idle("stats_idle", 600);
    chk("stat_frames", int'(stat_frames), 2);
    chk("stat_bytes", int'(stat_bytes), 192);
    chk("stat_len_err", int'(stat_len_err), 1);
`endif

    // Randomized descriptor stream against a frame-level model
    clear_mon();
    exp_errs = 0;
    zeros = 0;
    for (int k = 0; k < 25; k++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      len = 0;
      else if (r == 1) len = MAX_LEN + 1 + int'($urandom_range(0, 5));
      else             len = int'($urandom_range(1, 120));
      ptr_q.push_back({5'($urandom), 11'(len)});
      if (len == 0 || len > MAX_LEN) exp_errs++;
      if (len == 0) begin
        zeros++;
      end else begin
        if (exp_lens.size() > 0) exp_gaps.push_back(IFG_CYCLES + 2 + 2 * zeros);
        zeros = 0;
        exp_lens.push_back(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          data_q.push_back(b);
          exp_bytes.push_back(b);
        end
      end
    end
    wait_idle("rand_idle", 20000);
    chk("rand_len_err", err_cyc.size(), exp_errs);
    chk("rand_byte_cnt", tx_q.size(), exp_bytes.size());
    bad = 0;
    n = (tx_q.size() < exp_bytes.size()) ? tx_q.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) if (tx_q[i].d != exp_bytes[i]) bad++;
    chk("rand_bytes_bad", bad, 0);
    foreach (tx_q[i]) begin
      if (tx_q[i].sof) sof_cycs.push_back(tx_q[i].cyc);
      if (tx_q[i].eof) eof_cycs.push_back(tx_q[i].cyc);
    end
    chk("rand_sof_cnt", sof_cycs.size(), exp_lens.size());
    chk("rand_eof_cnt", eof_cycs.size(), exp_lens.size());
    nfr = sof_cycs.size();
    if (eof_cycs.size() < nfr) nfr = eof_cycs.size();
    if (exp_lens.size() < nfr) nfr = exp_lens.size();
    for (int k = 0; k < nfr; k++) begin
      chk($sformatf("rand_len%0d", k), eof_cycs[k] - sof_cycs[k] + 1, exp_lens[k]);
      if (k > 0) chk($sformatf("rand_gap%0d", k), sof_cycs[k] - eof_cycs[k-1] - 1, exp_gaps[k-1]);
    end

    chk("stray_sof_eof", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_egress_tx.md
Name: switch_egress_tx

Overview:
Per-port egress transmitter downstream of the post-switch output queues. It pops a frame descriptor from one port's pointer FIFO, then reads exactly that many bytes from the port's data FIFO. It emits a byte stream framed by sof/dv/eof, with an enforced inter-frame gap. Four instances, one per output port (0..3), sit after the switch top-level outputs.

Parameters:
- IFG_CYCLES, 10, minimum idle cycles inserted after the last data FIFO read of a frame (1..255).
- MAX_LEN, 1518, largest legal frame byte length. Larger lengths are still sent but flagged.
- LEN_W, 11, width of the length field in the pointer word.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ptr_fifo_empty  in  1  pointer FIFO empty.
- ptr_fifo_dout  in  16  descriptor: [LEN_W-1:0] frame byte length; [15:LEN_W] reserved, ignored.
- ptr_fifo_rd  out  1  pointer FIFO pop. Dout is valid the cycle after rd.
- data_fifo_dout  in  8  frame byte. Valid the cycle after data_fifo_rd.
- data_fifo_rd  out  1  data FIFO pop.
- tx_pause  in  1  downstream hold. Sampled only in IDLE.
- tx_sof  out  1  high with the first byte.
- tx_eof  out  1  high with the last byte.
- tx_dv  out  1  tx_dout valid.
- tx_dout  out  8  transmitted byte.
- busy  out  1  high in any state other than IDLE.
- len_err  out  1  one-cycle pulse for a bad descriptor length.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts the frame immediately; FIFO realignment is the upstream reset's job.
- All outputs are registered.
- FSM states: IDLE, LOAD, SEND, IFG.
- IDLE: if !ptr_fifo_empty && !tx_pause at cycle T, assert ptr_fifo_rd at T (one cycle) and go to LOAD.
- LOAD (T+1): latch len = ptr_fifo_dout[LEN_W-1:0].
  - len==0: pulse len_err at T+2, go to IDLE. No data is read.
  - len>MAX_LEN: pulse len_err at T+2 and proceed normally, so the data FIFO stays aligned.
  - Otherwise go to SEND.
- SEND: data_fifo_rd high on consecutive cycles T+2..T+1+len, driven by a down-counter.
  - Captured bytes appear as tx_dout/tx_dv on T+4..T+3+len (2-cycle read-to-output pipeline).
  - tx_sof at T+4 only; tx_eof at T+3+len only. For len==1, sof and eof are asserted together.
  - After the last rd, go to IFG.
- IFG: count IFG_CYCLES cycles, then go to IDLE.
  - Idle gap between tx_dv of consecutive frames is exactly IFG_CYCLES+2 cycles when the next descriptor is already waiting.
- tx_pause has no effect once a frame has left IDLE. Frames are never truncated.
- tx_dout holds its last value when tx_dv is low.
- Data FIFO empty during SEND is a system error: no stall, bytes are read as-is.
- The length counter is LEN_W bits and cannot wrap, because len ≤ 2^LEN_W-1.

Optional Feature:
- Macro: SWITCH_EGRESS_STATS_EN.
- When defined, adds outputs:
  - stat_frames (32 bit): +1 per tx_eof.
  - stat_bytes (32 bit): +1 per tx_dv cycle.
  - stat_len_err (16 bit): +1 per len_err.
- All three reset to 0 and wrap modulo 2^N.
- When undefined, these ports and their logic do not exist. Core timing is identical in both builds.

Decomposition:
- Shared package switch_egress_pkg holds:
  - state enum (IDLE/LOAD/SEND/IFG);
  - PTR_W=16 and the length-field slice constants;
  - statistics counter widths.
- One natural sub-module: switch_egress_stats (the counter bank), instantiated only under SWITCH_EGRESS_STATS_EN.

Test Plan:
- One descriptor len=64, bytes 0x00..0x3F, pop at T -> data_fifo_rd T+2..T+65; tx_dv T+4..T+67; sof at T+4 with dout 0x00; eof at T+67 with dout 0x3F.
- Two back-to-back descriptors len=60, IFG_CYCLES=10 -> exactly 12 idle cycles between the first frame's eof and the second frame's sof; byte order preserved.
- Descriptor len=0 followed by len=1 (byte 0xA5) -> len_err pulses once; no data_fifo_rd for the first; second frame has sof=eof=1 and dout 0xA5.
- tx_pause=1 with the pointer FIFO non-empty for 20 cycles -> no ptr_fifo_rd. Assert pause during SEND -> frame completes unchanged.
- Reset asserted mid-SEND of a len=100 frame -> all outputs 0 in the same cycle; after release with the FIFO empty, state stays IDLE and busy=0.
- With SWITCH_EGRESS_STATS_EN, send frames of len 64, 0, 128 -> stat_frames=2, stat_bytes=192, stat_len_err=1.
